// File: rtl/rr_pkt_sched.sv
// Packet-granular weighted round-robin scheduler: grant locks for a whole packet and holds for weight[i] packets.
// One-cycle req->gnt latency, same-cycle re-arbitration on release; dst_rdy=0 holds sel; RR_PKT_SCHED_WDOG_EN adds a stall watchdog.
module rr_pkt_sched #(
    parameter int NUM_OF_INPUT = 20,
    parameter int INPUT_NBITS  = 5,
    parameter int WEIGHT_NBITS = 4,
    parameter int WDOG_NBITS   = 8
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [NUM_OF_INPUT-1:0]              req,
    input  logic [NUM_OF_INPUT-1:0]              last,
    input  logic [NUM_OF_INPUT*WEIGHT_NBITS-1:0] weight,
    input  logic                                 en,
    input  logic                                 dst_rdy,
    output logic [NUM_OF_INPUT-1:0]              ack,
    output logic [INPUT_NBITS-1:0]               sel,
    output logic                                 gnt,
    output logic                                 err_timeout
);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t                  state, state_nxt;
    logic [INPUT_NBITS-1:0]  sel_nxt, ptr, ptr_nxt, arb_ptr, winner;
    logic [WEIGHT_NBITS-1:0] pkt_cnt, cnt_nxt, w_sel, eff_w;
    logic [WEIGHT_NBITS:0]   cnt_inc;
    logic                    in_pkt, in_pkt_nxt;
    logic                    req_sel, last_sel, beat, last_beat, quota_done, rel, wd_fire;

    if ((2 ** INPUT_NBITS) < NUM_OF_INPUT || WDOG_NBITS < 1) begin : g_bad_cfg
        $error("rr_pkt_sched: inconsistent parameters");
    end

    // First set bit strictly after p, wrapping; p itself is checked last.
    function automatic logic [INPUT_NBITS-1:0] rr_pick(input logic [NUM_OF_INPUT-1:0] r,
                                                        input logic [INPUT_NBITS-1:0]  p);
        logic [INPUT_NBITS-1:0] win;
        int                     idx;
        win = p;
        for (int k = NUM_OF_INPUT; k >= 1; k--) begin
            idx = int'(p) + k;
            if (idx >= NUM_OF_INPUT) idx = idx - NUM_OF_INPUT;
            if (r[idx]) win = INPUT_NBITS'(idx);
        end
        return win;
    endfunction

    assign gnt       = (state == XFER);
    assign req_sel   = req[sel];
    assign last_sel  = last[sel];
    assign beat      = gnt & req_sel & dst_rdy;
    assign last_beat = beat & last_sel;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_OF_INPUT; i++) begin
            if (sel == INPUT_NBITS'(i)) w_sel = weight[i*WEIGHT_NBITS +: WEIGHT_NBITS];
        end
    end

    assign eff_w      = (w_sel == '0) ? WEIGHT_NBITS'(1) : w_sel;
    assign cnt_inc    = {1'b0, pkt_cnt} + {{WEIGHT_NBITS{1'b0}}, 1'b1};
    assign quota_done = (cnt_inc >= {1'b0, eff_w});

    // Release: quantum spent (or en low) at a last beat, owner idle at a packet boundary, or watchdog.
    assign rel = gnt & ((last_beat & (quota_done | ~en)) | (~in_pkt & ~req_sel) | wd_fire);

    always_comb begin
        ack = '0;
        if (beat) ack[sel] = 1'b1;
    end

    assign arb_ptr = gnt ? sel : ptr;
    assign winner  = rr_pick(req, arb_ptr);

    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        ptr_nxt    = ptr;
        cnt_nxt    = pkt_cnt;
        in_pkt_nxt = in_pkt;
        case (state)
            IDLE: begin
                if (en && (|req)) begin
                    state_nxt  = XFER;
                    sel_nxt    = winner;
                    cnt_nxt    = '0;
                    in_pkt_nxt = 1'b0;
                end
            end
            XFER: begin
                if (rel) begin
                    ptr_nxt    = sel;
                    in_pkt_nxt = 1'b0;
                    cnt_nxt    = '0;
                    if (en && (|req)) sel_nxt = winner;
                    else              state_nxt = IDLE;
                end else if (beat) begin
                    in_pkt_nxt = ~last_sel;
                    if (last_sel && !(&pkt_cnt)) cnt_nxt = cnt_inc[WEIGHT_NBITS-1:0];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            sel     <= '0;
            ptr     <= INPUT_NBITS'(NUM_OF_INPUT - 1);
            pkt_cnt <= '0;
            in_pkt  <= 1'b0;
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            ptr     <= ptr_nxt;
            pkt_cnt <= cnt_nxt;
            in_pkt  <= in_pkt_nxt;
        end
    end

`ifdef RR_PKT_SCHED_WDOG_EN
    logic [WDOG_NBITS-1:0] wd_cnt;
    logic                  err_q;

    assign wd_fire     = gnt & (&wd_cnt) & ~beat;
    assign err_timeout = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= wd_fire;
            if (!gnt || beat || rel) wd_cnt <= '0;
            else                     wd_cnt <= wd_cnt + {{(WDOG_NBITS-1){1'b0}}, 1'b1};
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_pkt_sched.sv
// Randomized bench for rr_pkt_sched against a cycle-level reference of the scheduling rules.
module tb_rr_pkt_sched;
    localparam int N  = 20;
    localparam int SB = 5;
    localparam int WB = 4;
    localparam int WD = 4;
`ifdef RR_PKT_SCHED_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [N-1:0]  req = '0, last = '0, ack;
    logic [N*WB-1:0] weight = '0;
    logic          en = 1'b0, dst_rdy = 1'b0;
    logic [SB-1:0] sel;
    logic          gnt, err_timeout;

    rr_pkt_sched #(.NUM_OF_INPUT(N), .INPUT_NBITS(SB), .WEIGHT_NBITS(WB), .WDOG_NBITS(WD)) dut (
        .clk(clk), .rstn(rstn), .req(req), .last(last), .weight(weight), .en(en),
        .dst_rdy(dst_rdy), .ack(ack), .sel(sel), .gnt(gnt), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state and traffic sources
    int m_gnt, m_sel, m_ptr, m_cnt, m_inpkt, m_wd, m_err;
    int w[N];
    int plen[N], pidx[N];
    bit act[N];
    int start_pct, len_lo, len_hi, rdy_pct, en_pct;
    int ack_cnt[N];
    int order[$];
    int err_cnt, seen_gnt, gap_cnt;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return p;
    endfunction

    task automatic clear_all();
        m_gnt = 0; m_sel = 0; m_ptr = N - 1; m_cnt = 0; m_inpkt = 0; m_wd = 0; m_err = 0;
        for (int i = 0; i < N; i++) begin
            plen[i] = 0; pidx[i] = 0; act[i] = 0; ack_cnt[i] = 0; w[i] = 1;
        end
        order.delete();
        err_cnt = 0; seen_gnt = 0; gap_cnt = 0;
        start_pct = 100; len_lo = 1; len_hi = 1; rdy_pct = 100; en_pct = 100;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rstn = 1'b0;
        req = '0; last = '0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_sel", sel, 0);
        check("rst_err", err_timeout, 0);
        check("rst_ack", ack, 0);
        clear_all();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic step();
        logic [N-1:0] eack;
        bit beat, fin, rel, wfire;
        int eff, osel;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (plen[i] == 0 && act[i] && $urandom_range(99) < start_pct) begin
                plen[i] = $urandom_range(len_hi, len_lo);
                pidx[i] = 0;
            end
            req[i]  = (plen[i] != 0);
            last[i] = (plen[i] != 0) && (pidx[i] == plen[i] - 1);
            weight[i*WB +: WB] = WB'(w[i]);
        end
        dst_rdy = ($urandom_range(99) < rdy_pct);
        en      = ($urandom_range(99) < en_pct);
        #1;
        osel = m_sel;
        beat = (m_gnt != 0) && req[osel] && dst_rdy;
        eack = '0;
        if (beat) eack[osel] = 1'b1;
        check("gnt", gnt, m_gnt);
        check("sel", sel, m_sel);
        check("ack", ack, eack);
        check("err_timeout", err_timeout, m_err);
        for (int i = 0; i < N; i++) begin
            if (ack[i]) ack_cnt[i]++;
            if (ack[i] && last[i]) order.push_back(i);
        end
        if (err_timeout) err_cnt++;
        if (gnt) seen_gnt = 1;
        else if (seen_gnt != 0) gap_cnt++;

        m_err = 0;
        if (m_gnt == 0) begin
            if (en && req != '0) begin
                m_gnt = 1; m_sel = pick(req, m_ptr); m_cnt = 0; m_inpkt = 0; m_wd = 0;
            end
        end else begin
            fin   = beat && last[osel];
            eff   = (w[osel] == 0) ? 1 : w[osel];
            wfire = WDOG_ON && (m_wd == (1 << WD) - 1) && !beat;
            rel   = (fin && (m_cnt + 1 >= eff || !en)) || (m_inpkt == 0 && !req[osel]) || wfire;
            m_err = wfire;
            if (rel) begin
                m_ptr = osel; m_inpkt = 0; m_cnt = 0; m_wd = 0;
                if (en && req != '0) m_sel = pick(req, osel);
                else                 m_gnt = 0;
            end else if (beat) begin
                m_wd = 0;
                m_inpkt = !last[osel];
                if (last[osel]) m_cnt++;
            end else begin
                m_wd++;
            end
        end
        if (beat) begin
            pidx[osel]++;
            if (pidx[osel] == plen[osel]) plen[osel] = 0;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    int rot_exp[4] = '{0, 5, 19, 0};
    int q_exp[8]   = '{2, 2, 2, 7, 2, 2, 2, 7};
    int z_exp[4]   = '{2, 7, 2, 7};

    initial begin
        clear_all();
        do_reset();

        // Single requester, one 4-beat packet, then req drops
        act[3] = 1; len_lo = 4; len_hi = 4;
        step();
        act[3] = 0;
        step();
        check("single_gnt", gnt, 1);
        check("single_sel", sel, 3);
        run(7);
        check("single_acks", ack_cnt[3], 4);
        check("single_gnt_drop", gnt, 0);

        // Rotation of single-beat packets, no bubble
        do_reset();
        act[0] = 1; act[5] = 1; act[19] = 1;
        run(8);
        for (int k = 0; k < 4; k++)
            check($sformatf("rot_%0d", k), (k < order.size()) ? order[k] : 99, rot_exp[k]);
        check("rot_gap", gap_cnt, 0);

        // Quantum 3 vs 1
        do_reset();
        w[2] = 3; w[7] = 1; act[2] = 1; act[7] = 1;
        run(11);
        for (int k = 0; k < 8; k++)
            check($sformatf("quant_%0d", k), (k < order.size()) ? order[k] : 99, q_exp[k]);

        // Weight 0 acts as 1
        do_reset();
        w[2] = 0; act[2] = 1; act[7] = 1;
        run(6);
        for (int k = 0; k < 4; k++)
            check($sformatf("w0_%0d", k), (k < order.size()) ? order[k] : 99, z_exp[k]);

        // Backpressure with a competing requester
        do_reset();
        act[4] = 1; len_lo = 4; len_hi = 4;
        step();
        act[4] = 0; act[9] = 1; len_lo = 1; len_hi = 1;
        step();
        rdy_pct = 0; run(2);
        check("bp_hold_sel", sel, 4);
        check("bp_acks_stalled", ack_cnt[4], 1);
        rdy_pct = 100; run(3);
        check("bp_acks_done", ack_cnt[4], 4);
        check("bp_no_ack9", ack_cnt[9], 0);
        step();
        check("bp_next_sel", sel, 9);

        // en gating mid-packet
        do_reset();
        act[6] = 1; len_lo = 4; len_hi = 4;
        step();
        act[6] = 0;
        step();
        check("en_sel6", sel, 6);
        en_pct = 0; act[1] = 1; len_lo = 1; len_hi = 1;
        run(6);
        check("en_off_gnt", gnt, 0);
        check("en_pkt_done", ack_cnt[6], 4);
        en_pct = 100;
        step();
        step();
        check("en_back_gnt", gnt, 1);
        check("en_back_sel", sel, 1);

`ifdef RR_PKT_SCHED_WDOG_EN
        // Watchdog release of a stalled grant
        do_reset();
        act[8] = 1; len_lo = 2; len_hi = 2;
        step();
        rdy_pct = 0; act[10] = 1;
        run(17);
        check("wd_err", err_timeout, 1);
        check("wd_sel", sel, 10);
        check("wd_gnt", gnt, 1);
        check("wd_pulses", err_cnt, 1);
`endif

        // Random traffic with an asynchronous reset in the middle
        do_reset();
        for (int i = 0; i < N; i++) begin
            act[i] = ($urandom_range(99) < 60);
            w[i]   = $urandom_range(3, 0);
        end
        start_pct = 40; len_lo = 1; len_hi = 4; rdy_pct = 70; en_pct = 90;
        run(1500);
        do_reset();
        for (int i = 0; i < N; i++) begin
            act[i] = 1;
            w[i]   = $urandom_range(15, 0);
        end
        start_pct = 50; len_lo = 1; len_hi = 5; rdy_pct = 60; en_pct = 95;
        run(1500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
